// File: rtl/draw_pkg.sv
// Shared entity field layout, drawer select codes and FSM encoding for the
// frame draw scheduler and its pixel mux.
package draw_pkg;

    localparam int ENTITY_SIZE    = 34;
    localparam int ALIVE_BIT      = 33;
    localparam int SPRITE_SEL_MSB = 32;
    localparam int SPRITE_SEL_LSB = 30;
    localparam int Y_MSB          = 25;
    localparam int Y_LSB          = 16;
    localparam int X_MSB          = 15;
    localparam int X_LSB          = 6;

    // One-hot drawer codes, same bit order as start/draw_done/d_plot.
    localparam logic [2:0] D_SHIP     = 3'b100;
    localparam logic [2:0] D_ASTEROID = 3'b010;
    localparam logic [2:0] D_SHOT     = 3'b001;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    // Slot 0 is the ship, then the asteroid slots, then the shot slots.
    function automatic logic [2:0] slot_type(input int slot, input int n_asteroids);
        if (slot == 0)
            return D_SHIP;
        else if (slot <= n_asteroids)
            return D_ASTEROID;
        else
            return D_SHOT;
    endfunction

endpackage

// File: rtl/draw_pixel_mux.sv
// Registered 3:1 pixel mux from the sprite drawers to the single VGA write port,
// with black forced during erase and plot gated outside ISSUE/WAIT.
module draw_pixel_mux (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  sel,
    input  logic        erase,
    input  logic        enable,
    input  logic [29:0] d_x,
    input  logic [29:0] d_y,
    input  logic [8:0]  d_color,
    input  logic [2:0]  d_plot,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [2:0]  color,
    output logic        plot
);

    logic [9:0] pick_x;
    logic [9:0] pick_y;
    logic [2:0] pick_color;
    logic       pick_plot;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pick_x     = '0;
        pick_y     = '0;
        pick_color = '0;
        pick_plot  = 1'b0;
        if (sel[2]) begin
            pick_x     = d_x[29:20];
            pick_y     = d_y[29:20];
            pick_color = d_color[8:6];
            pick_plot  = d_plot[2];
        end else if (sel[1]) begin
            pick_x     = d_x[19:10];
            pick_y     = d_y[19:10];
            pick_color = d_color[5:3];
            pick_plot  = d_plot[1];
        end else if (sel[0]) begin
            pick_x     = d_x[9:0];
            pick_y     = d_y[9:0];
            pick_color = d_color[2:0];
            pick_plot  = d_plot[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
        end else begin
            x     <= pick_x;
            y     <= pick_y;
            color <= erase ? 3'b000 : pick_color;
            plot  <= enable & pick_plot;
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Frame sequencer: snapshots the entity registers on a frame tick, then runs an
// erase pass over the previous snapshot and a draw pass over the new one.
module frame_draw_scheduler #(
    parameter int ENTITY_SIZE   = draw_pkg::ENTITY_SIZE,
    parameter int MAX_ASTEROIDS = 5,
    parameter int MAX_SHOTS     = 10,
    parameter int TIMEOUT       = 4095
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_tick,
    input  logic [ENTITY_SIZE-1:0]             ship_reg,
    input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroid_reg,
    input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]   shot_reg,
    output logic [ENTITY_SIZE-1:0]             entity,
    output logic                               erase,
    output logic [2:0]                         start,
    input  logic [2:0]                         draw_done,
    input  logic [29:0]                        d_x,
    input  logic [29:0]                        d_y,
    input  logic [8:0]                         d_color,
    input  logic [2:0]                         d_plot,
    output logic [9:0]                         x,
    output logic [9:0]                         y,
    output logic [2:0]                         color,
    output logic                               plot,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               overrun,
    output logic                               timeout
);
    import draw_pkg::*;

    localparam int              N       = 1 + MAX_ASTEROIDS + MAX_SHOTS;
    localparam int              IW      = $clog2(N);
    localparam logic [IW-1:0]   LAST    = IW'(N - 1);
    localparam logic [11:0]     TO_LAST = 12'(TIMEOUT - 1);

    logic [2:0]             state;
    logic                   phase_erase;
    logic [IW-1:0]          idx;
    logic [11:0]            wait_cnt;
    logic [ENTITY_SIZE-1:0] prev_snap [N];
    logic [ENTITY_SIZE-1:0] cur_snap  [N];

    logic [ENTITY_SIZE-1:0] slot_word;
    logic [2:0]             slot_code;
    logic                   live;
    logic                   active;
    logic                   done_hit;
    logic                   wait_expired;

    always_comb begin
        slot_word    = phase_erase ? prev_snap[idx] : cur_snap[idx];
        slot_code    = slot_type(int'(idx), MAX_ASTEROIDS);
        live         = slot_word[ALIVE_BIT];
        active       = (state == S_ISSUE) || (state == S_WAIT);
        done_hit     = |(draw_done & slot_code);
        wait_expired = (wait_cnt == TO_LAST);
    end

    assign busy       = (state != S_IDLE);
    assign erase      = phase_erase;
    assign entity     = active ? slot_word : '0;
    assign start      = (state == S_ISSUE && live) ? slot_code : 3'b000;
    assign frame_done = (state == S_NEXT) && !phase_erase && (idx == LAST);
    assign timeout    = (state == S_WAIT) && !done_hit && wait_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            phase_erase <= 1'b0;
            idx         <= '0;
            wait_cnt    <= '0;
            overrun     <= 1'b0;
        end else begin
            // A tick outside IDLE is reported and dropped; the running frame carries on.
            overrun <= frame_tick && (state != S_IDLE);
            case (state)
                S_IDLE: if (frame_tick) state <= S_LOAD;
                S_LOAD: begin
                    phase_erase <= 1'b1;
                    idx         <= '0;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= live ? S_WAIT : S_NEXT;
                end
                S_WAIT: begin
                    if (done_hit || wait_expired)
                        state <= S_NEXT;
                    else
                        wait_cnt <= wait_cnt + 12'd1;
                end
                S_NEXT: begin
                    if (idx != LAST) begin
                        idx   <= idx + IW'(1);
                        state <= S_ISSUE;
                    end else if (phase_erase) begin
                        phase_erase <= 1'b0;
                        idx         <= '0;
                        state       <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the snapshot arrays are cleared on reset so the first erase pass after reset draws nothing.
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                prev_snap[i] <= '0;
                cur_snap[i]  <= '0;
            end
        end else if (state == S_LOAD) begin
            prev_snap   <= cur_snap;
            cur_snap[0] <= ship_reg;
            for (int i = 0; i < MAX_ASTEROIDS; i++)
                cur_snap[1 + i] <= asteroid_reg[i*ENTITY_SIZE +: ENTITY_SIZE];
            for (int i = 0; i < MAX_SHOTS; i++)
                cur_snap[1 + MAX_ASTEROIDS + i] <= shot_reg[i*ENTITY_SIZE +: ENTITY_SIZE];
        end
    end

    draw_pixel_mux u_pixel_mux (
        .clk     (clk),
        .reset   (reset),
        .sel     (slot_code),
        .erase   (phase_erase),
        .enable  (active),
        .d_x     (d_x),
        .d_y     (d_y),
        .d_color (d_color),
        .d_plot  (d_plot),
        .x       (x),
        .y       (y),
        .color   (color),
        .plot    (plot)
    );

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Self-checking bench: a per-frame cycle plan is built from the sequencing rules
// and drives the drawer handshakes while every DUT output is compared each cycle.
module tb_frame_draw_scheduler;

    localparam int NA = 3;
    localparam int NS = 2;
    localparam int N  = 1 + NA + NS;
    localparam int ES = 34;
    localparam int TO = 4095;

    logic              clk;
    logic              reset;
    logic              frame_tick;
    logic [ES-1:0]     ship_reg;
    logic [NA*ES-1:0]  asteroid_reg;
    logic [NS*ES-1:0]  shot_reg;
    logic [ES-1:0]     entity;
    logic              erase;
    logic [2:0]        start;
    logic [2:0]        draw_done;
    logic [29:0]       d_x;
    logic [29:0]       d_y;
    logic [8:0]        d_color;
    logic [2:0]        d_plot;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [2:0]        color;
    logic              plot;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              timeout;

    frame_draw_scheduler #(
        .ENTITY_SIZE   (ES),
        .MAX_ASTEROIDS (NA),
        .MAX_SHOTS     (NS),
        .TIMEOUT       (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .ship_reg     (ship_reg),
        .asteroid_reg (asteroid_reg),
        .shot_reg     (shot_reg),
        .entity       (entity),
        .erase        (erase),
        .start        (start),
        .draw_done    (draw_done),
        .d_x          (d_x),
        .d_y          (d_y),
        .d_color      (d_color),
        .d_plot       (d_plot),
        .x            (x),
        .y            (y),
        .color        (color),
        .plot         (plot),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // One planned clock cycle: stimulus to drive plus the expected outputs.
    typedef struct {
        bit            tick;
        bit [2:0]      done;
        bit            busy;
        bit            erase;
        bit            active;
        bit            is_wait;
        bit [2:0]      start;
        bit [2:0]      sel;
        logic [ES-1:0] entity;
        bit            frame_done;
        bit            timeout;
    } cyc_t;

    cyc_t          plan[$];
    logic [ES-1:0] in_words [N];
    logic [ES-1:0] m_prev   [N];
    logic [ES-1:0] m_cur    [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Previous-cycle context for the registered pixel path and overrun.
    bit          p_tick, p_busy, p_active, p_erase;
    bit [2:0]    p_sel;
    logic [29:0] p_dx, p_dy;
    logic [8:0]  p_dc;
    logic [2:0]  p_dp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] kind(input int i);
        if (i == 0) return 3'b100;
        if (i <= NA) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [9:0] pick10(input logic [29:0] v, input logic [2:0] s);
        case (s)
            3'b100:  return v[29:20];
            3'b010:  return v[19:10];
            default: return v[9:0];
        endcase
    endfunction

    function automatic logic [2:0] pick3(input logic [8:0] v, input logic [2:0] s);
        case (s)
            3'b100:  return v[8:6];
            3'b010:  return v[5:3];
            default: return v[2:0];
        endcase
    endfunction

    function automatic logic [ES-1:0] mk(input bit alive, input logic [9:0] px, input logic [9:0] py);
        return {alive, 3'b001, 4'b0000, py, px, 6'd5};
    endfunction

    function automatic logic [ES-1:0] mkrand(input bit alive);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {alive, r[32:0]};
    endfunction

    task automatic apply_inputs();
        ship_reg = in_words[0];
        for (int i = 0; i < NA; i++) asteroid_reg[i*ES +: ES] = in_words[1 + i];
        for (int i = 0; i < NS; i++) shot_reg[i*ES +: ES] = in_words[1 + NA + i];
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N; i++) begin
            logic [ES-1:0] w;
            w = mkrand(1'b1);
            if (i == 0) ship_reg = w;
            else if (i <= NA) asteroid_reg[(i-1)*ES +: ES] = w;
            else shot_reg[(i-1-NA)*ES +: ES] = w;
        end
    endtask

    task automatic clear_ctx();
        p_tick = 0; p_busy = 0; p_active = 0; p_erase = 0; p_sel = 0;
        p_dx = '0; p_dy = '0; p_dc = '0; p_dp = '0;
    endtask

    // Expected cycle sequence of one frame started from IDLE with the current inputs.
    task automatic build_frame(input int hang_slot, input bit noise);
        cyc_t          c;
        logic [ES-1:0] w;
        logic [2:0]    code;
        int            lat;
        bit            hang;
        apply_inputs();
        plan.delete();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = m_cur[i];
            m_cur[i]  = in_words[i];
        end
        c = '{default: 0}; c.tick = 1;
        plan.push_back(c);
        c = '{default: 0}; c.busy = 1;
        plan.push_back(c);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                w    = (p == 0) ? m_prev[i] : m_cur[i];
                code = kind(i);
                c = '{default: 0};
                c.busy = 1; c.erase = (p == 0); c.active = 1; c.sel = code; c.entity = w;
                if (w[ES-1]) begin
                    c.start = code;
                    if (noise) c.done = code;
                end
                plan.push_back(c);
                if (w[ES-1]) begin
                    hang = (p == 1) && (i == hang_slot);
                    lat  = hang ? TO : int'($urandom_range(6, 1));
                    for (int k = 1; k <= lat; k++) begin
                        c.start   = 3'b000;
                        c.is_wait = 1;
                        c.done    = noise ? (3'($urandom) & ~code) : 3'b000;
                        if (k == lat) begin
                            if (hang) c.timeout = 1;
                            else c.done = c.done | code;
                        end
                        plan.push_back(c);
                    end
                end
                c = '{default: 0};
                c.busy = 1; c.erase = (p == 0);
                c.frame_done = (p == 1) && (i == N - 1);
                if (noise) c.done = 3'($urandom);
                plan.push_back(c);
            end
        end
        c = '{default: 0};
        plan.push_back(c);
        plan.push_back(c);
    endtask

    task automatic step(input cyc_t r);
        @(posedge clk);
        #1;
        cyc++;
        frame_tick = r.tick;
        draw_done  = r.done;
        d_x        = 30'($urandom);
        d_y        = 30'($urandom);
        d_color    = 9'($urandom);
        d_plot     = 3'($urandom);
        @(negedge clk);
        check("busy", 64'(busy), 64'(r.busy));
        check("erase", 64'(erase), 64'(r.erase));
        check("start", 64'(start), 64'(r.start));
        check("frame_done", 64'(frame_done), 64'(r.frame_done));
        check("timeout", 64'(timeout), 64'(r.timeout));
        check("overrun", 64'(overrun), 64'(p_tick && p_busy));
        if (r.active) check("entity", 64'(entity), 64'(r.entity));
        else if (!r.busy) check("entity_idle", 64'(entity), 64'd0);
        check("plot", 64'(plot), 64'(p_active && ((p_dp & p_sel) != 3'b000)));
        if (p_active) begin
            check("pix_x", 64'(x), 64'(pick10(p_dx, p_sel)));
            check("pix_y", 64'(y), 64'(pick10(p_dy, p_sel)));
            check("pix_color", 64'(color), p_erase ? 64'd0 : 64'(pick3(p_dc, p_sel)));
        end
        p_tick = r.tick; p_busy = r.busy; p_active = r.active; p_erase = r.erase; p_sel = r.sel;
        p_dx = d_x; p_dy = d_y; p_dc = d_color; p_dp = d_plot;
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) begin
            step(plan[k]);
            if (k == 2) scramble_inputs();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_erase"}, 64'(erase), 64'd0);
        check({tag, "_start"}, 64'(start), 64'd0);
        check({tag, "_entity"}, 64'(entity), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_plot"}, 64'(plot), 64'd0);
        check({tag, "_xy"}, 64'({x, y}), 64'd0);
        check({tag, "_color"}, 64'(color), 64'd0);
    endtask

    task automatic mark_tick(input bit at_wait);
        for (int k = 0; k < plan.size(); k++) begin
            if ((at_wait && plan[k].is_wait) || (!at_wait && plan[k].frame_done)) begin
                plan[k].tick = 1;
                break;
            end
        end
    endtask

    initial begin
        int w_idx;
        reset = 1'b1;
        frame_tick = 1'b0; draw_done = '0;
        d_x = '0; d_y = '0; d_color = '0; d_plot = '0;
        for (int i = 0; i < N; i++) begin
            in_words[i] = '0; m_prev[i] = '0; m_cur[i] = '0;
        end
        apply_inputs();
        clear_ctx();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Ship only, x=9 y=0: erase pass empty, one ship start in the draw pass.
        in_words[0] = mk(1'b1, 10'd9, 10'd0);
        build_frame(-1, 1'b0);
        run_steps(plan.size());

        // Ship moved to x=20: erase redraws x=9 in black, then draws x=20.
        in_words[0] = mk(1'b1, 10'd20, 10'd0);
        build_frame(-1, 1'b0);
        run_steps(plan.size());

        // Asteroids 0 and 2 alive, asteroid 1 dead; ticks in WAIT and in the frame_done cycle.
        for (int i = 0; i < N; i++) in_words[i] = '0;
        in_words[1] = mkrand(1'b1);
        in_words[3] = mkrand(1'b1);
        build_frame(-1, 1'b1);
        mark_tick(1'b1);
        mark_tick(1'b0);
        run_steps(plan.size());

        // Random populations with spurious done bits.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) in_words[i] = mkrand(1'($urandom));
            build_frame(-1, 1'b1);
            run_steps(plan.size());
        end

        // Ship drawer never finishes in the draw pass: timeout, then the frame completes.
        for (int i = 0; i < N; i++) in_words[i] = mkrand(1'b0);
        in_words[0] = mkrand(1'b1);
        in_words[4] = mkrand(1'b1);
        build_frame(0, 1'b0);
        run_steps(plan.size());

        // Reset while waiting on a drawer.
        for (int i = 0; i < N; i++) in_words[i] = mkrand(1'b1);
        build_frame(-1, 1'b1);
        w_idx = 0;
        for (int k = plan.size() - 1; k >= 0; k--) if (plan[k].is_wait) w_idx = k;
        run_steps(w_idx + 1);
        check("busy_before_reset", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        frame_tick = 1'b0; draw_done = '0; d_plot = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_prev[i] = '0; m_cur[i] = '0;
        end
        clear_ctx();

        // First frame after reset: empty erase pass, full draw pass.
        build_frame(-1, 1'b0);
        run_steps(plan.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
